// File: rtl/writeback_stage.sv
// Writeback stage: pending-write FIFO that merges ALU and load results into one register-file write port.
// Define WRITEBACK_STAGE_BYPASS_EN to build the forwarding compare logic; otherwise fwd_* outputs are tied to 0.
module writeback_stage #(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    alu_valid,
  output logic                    alu_ready,
  input  logic [4:0]              alu_addr,
  input  logic [63:0]             alu_data,
  input  logic                    alu_imm_sel,
  input  logic [11:0]             alu_imm,
  input  logic                    mem_valid,
  output logic                    mem_ready,
  input  logic [4:0]              mem_addr,
  input  logic [63:0]             mem_data,
  input  logic                    rf_stall,
  output logic                    rf_w_en,
  output logic [4:0]              rf_addr,
  output logic [63:0]             rf_data,
  output logic [$clog2(DEPTH):0]  count,
  input  logic [4:0]              fwd_addr_1,
  input  logic [4:0]              fwd_addr_2,
  output logic                    fwd_hit_1,
  output logic                    fwd_hit_2,
  output logic [63:0]             fwd_data_1,
  output logic [63:0]             fwd_data_2
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]    r_fifo_addr [DEPTH];
  logic [63:0]   r_fifo_data [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_rf_w_en;
  logic [4:0]    r_rf_addr;
  logic [63:0]   r_rf_data;

  logic          w_space;
  logic          w_mem_push;
  logic          w_alu_push;
  logic          w_push;
  logic          w_out_free;
  logic          w_pop;
  logic [4:0]    w_push_addr;
  logic [63:0]   w_push_data;
  logic [63:0]   w_alu_payload;

  // Readiness depends only on the current occupancy, never on a same-cycle pop.
  assign w_space    = (r_count < CW'(DEPTH));
  assign mem_ready  = rst_n & w_space & ~flush;
  assign alu_ready  = rst_n & w_space & ~flush & ~mem_valid;
  assign w_mem_push = mem_valid & mem_ready;
  assign w_alu_push = alu_valid & alu_ready;
  assign w_push     = w_mem_push | w_alu_push;
  assign w_out_free = ~r_rf_w_en | ~rf_stall;
  assign w_pop      = w_out_free & (r_count != {CW{1'b0}});

  // Select the channel and payload being pushed this cycle
  always_comb begin
    w_alu_payload = alu_data;
    w_push_addr   = alu_addr;
    w_push_data   = alu_data;
    if (alu_imm_sel) begin
      w_alu_payload = {52'd0, alu_imm};
    end else begin
      w_alu_payload = alu_data;
    end
    if (w_mem_push) begin
      w_push_addr = mem_addr;
      w_push_data = mem_data;
    end else begin
      w_push_addr = alu_addr;
      w_push_data = w_alu_payload;
    end
  end

  // FIFO storage; entries are only meaningful inside the rptr..wptr window
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_addr[r_wptr] <= w_push_addr;
      r_fifo_data[r_wptr] <= w_push_data;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= {AW{1'b0}};
      r_rptr  <= {AW{1'b0}};
      r_count <= {CW{1'b0}};
    end else if (flush) begin
      r_wptr  <= {AW{1'b0}};
      r_rptr  <= {AW{1'b0}};
      r_count <= {CW{1'b0}};
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1'b1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1'b1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1'b1);
        2'b01:   r_count <= r_count - CW'(1'b1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Registered register-file write port; holds while stalled, flush wins over stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rf_w_en <= 1'b0;
      r_rf_addr <= 5'd0;
      r_rf_data <= 64'd0;
    end else if (flush) begin
      r_rf_w_en <= 1'b0;
    end else if (w_pop) begin
      r_rf_w_en <= 1'b1;
      r_rf_addr <= r_fifo_addr[r_rptr];
      r_rf_data <= r_fifo_data[r_rptr];
    end else if (w_out_free) begin
      r_rf_w_en <= 1'b0;
    end
  end

  assign rf_w_en = r_rf_w_en;
  assign rf_addr = r_rf_addr;
  assign rf_data = r_rf_data;
  assign count   = r_count;

`ifdef WRITEBACK_STAGE_BYPASS_EN
  logic [64:0] w_fwd_1;
  logic [64:0] w_fwd_2;

  // Scan head to tail so the youngest matching entry is the one kept.
  function automatic logic [64:0] fwd_lookup(input logic [4:0] a);
    logic [64:0]   res;
    logic [AW-1:0] idx;
    res = (r_rf_w_en && (r_rf_addr == a)) ? {1'b1, r_rf_data} : 65'd0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = r_rptr + AW'(k);
      res = ((CW'(k) < r_count) && (r_fifo_addr[idx] == a)) ? {1'b1, r_fifo_data[idx]} : res;
    end
    return res;
  endfunction

  // Forwarding compare for both read ports
  always_comb begin
    w_fwd_1 = fwd_lookup(fwd_addr_1);
    w_fwd_2 = fwd_lookup(fwd_addr_2);
  end

  assign {fwd_hit_1, fwd_data_1} = w_fwd_1;
  assign {fwd_hit_2, fwd_data_2} = w_fwd_2;
`else
  logic w_unused_fwd;
  assign w_unused_fwd = ^{fwd_addr_1, fwd_addr_2};
  assign fwd_hit_1    = 1'b0;
  assign fwd_hit_2    = 1'b0;
  assign fwd_data_1   = 64'd0;
  assign fwd_data_2   = 64'd0;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: directed pushes queue their expected writes; a negedge monitor
// compares each write the register file consumes (rf_w_en && !rf_stall) against the queue.
module tb_writeback_stage;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n, flush;
  logic        alu_valid, alu_ready, alu_imm_sel;
  logic [4:0]  alu_addr;
  logic [63:0] alu_data;
  logic [11:0] alu_imm;
  logic        mem_valid, mem_ready;
  logic [4:0]  mem_addr;
  logic [63:0] mem_data;
  logic        rf_stall, rf_w_en;
  logic [4:0]  rf_addr;
  logic [63:0] rf_data;
  logic [$clog2(DEPTH):0] count;
  logic [4:0]  fwd_addr_1, fwd_addr_2;
  logic        fwd_hit_1, fwd_hit_2;
  logic [63:0] fwd_data_1, fwd_data_2;

  int checks = 0;
  int failures = 0;
  logic [68:0] exp_q[$];

  writeback_stage #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .alu_imm_sel(alu_imm_sel), .alu_imm(alu_imm),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .rf_stall(rf_stall), .rf_w_en(rf_w_en), .rf_addr(rf_addr), .rf_data(rf_data),
    .count(count), .fwd_addr_1(fwd_addr_1), .fwd_addr_2(fwd_addr_2),
    .fwd_hit_1(fwd_hit_1), .fwd_hit_2(fwd_hit_2), .fwd_data_1(fwd_data_1), .fwd_data_2(fwd_data_2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [68:0] act, input logic [68:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: one comparison per consumed register-file write
  always @(negedge clk) begin
    if (rst_n && rf_w_en && !rf_stall) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected: got addr %0d data 0x%0h expected no write", rf_addr, rf_data);
      end else begin
        chk("sb_write", {rf_addr, rf_data}, exp_q.pop_front());
      end
    end
  end

  task automatic push_alu(input logic [4:0] a, input logic [63:0] d, input logic sel,
                          input logic [11:0] imm, input logic [63:0] exp_d);
    alu_valid = 1'b1; alu_addr = a; alu_data = d; alu_imm_sel = sel; alu_imm = imm;
    #1;
    chk("alu_ready", 69'(alu_ready), 69'(1'b1));
    exp_q.push_back({a, exp_d});
    @(posedge clk); #1;
    alu_valid = 1'b0; alu_imm_sel = 1'b0;
  endtask

  task automatic push_mem(input logic [4:0] a, input logic [63:0] d);
    mem_valid = 1'b1; mem_addr = a; mem_data = d;
    #1;
    chk("mem_ready", 69'(mem_ready), 69'(1'b1));
    exp_q.push_back({a, d});
    @(posedge clk); #1;
    mem_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; rf_stall = 1'b0;
    alu_valid = 1'b0; alu_addr = 5'd0; alu_data = 64'd0; alu_imm_sel = 1'b0; alu_imm = 12'd0;
    mem_valid = 1'b0; mem_addr = 5'd0; mem_data = 64'd0;
    fwd_addr_1 = 5'd0; fwd_addr_2 = 5'd0;
    #12;
    chk("rst_w_en", 69'(rf_w_en), 69'(1'b0));
    chk("rst_addr", 69'(rf_addr), 69'(5'd0));
    chk("rst_data", 69'(rf_data), 69'(64'd0));
    chk("rst_count", 69'(count), 69'(3'd0));
    chk("rst_alu_ready", 69'(alu_ready), 69'(1'b0));
    chk("rst_mem_ready", 69'(mem_ready), 69'(1'b0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // single write, accepted on the first edge after reset release
    push_alu(5'd5, 64'hDEAD_BEEF, 1'b0, 12'd0, 64'hDEAD_BEEF);
    @(posedge clk); #1;
    chk("single_w_en", 69'(rf_w_en), 69'(1'b1));
    chk("single_addr", 69'(rf_addr), 69'(5'd5));
    chk("single_data", 69'(rf_data), 69'(64'hDEAD_BEEF));
    @(posedge clk); #1;
    chk("single_w_en_off", 69'(rf_w_en), 69'(1'b0));

    // arbitration: memory channel wins
    alu_valid = 1'b1; alu_addr = 5'd1; alu_data = 64'h111;
    mem_valid = 1'b1; mem_addr = 5'd2; mem_data = 64'h222;
    #1;
    chk("arb_alu_ready", 69'(alu_ready), 69'(1'b0));
    chk("arb_mem_ready", 69'(mem_ready), 69'(1'b1));
    exp_q.push_back({5'd2, 64'h222});
    @(posedge clk); #1;
    mem_valid = 1'b0;
    #1;
    chk("arb_alu_ready2", 69'(alu_ready), 69'(1'b1));
    exp_q.push_back({5'd1, 64'h111});
    @(posedge clk); #1;
    alu_valid = 1'b0;
    repeat (4) @(posedge clk); #1;
    chk("arb_drain", 69'(exp_q.size()), 69'(0));

    // immediate select
    push_alu(5'd3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 12'hABC, 64'h0000_0000_0000_0ABC);
    @(posedge clk); #1;
    chk("imm_data", 69'(rf_data), 69'(64'h0000_0000_0000_0ABC));
    chk("imm_addr", 69'(rf_addr), 69'(5'd3));
    repeat (2) @(posedge clk); #1;

    // full / stall: 5 pushes, 4 in FIFO plus one held in the output register
    rf_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i % 2 == 0) push_mem(5'(16 + i), 64'h1000 + 64'(i));
      else            push_alu(5'(16 + i), 64'h1000 + 64'(i), 1'b0, 12'd0, 64'h1000 + 64'(i));
    end
    chk("full_count", 69'(count), 69'(3'd4));
    chk("full_mem_ready", 69'(mem_ready), 69'(1'b0));
    chk("full_alu_ready", 69'(alu_ready), 69'(1'b0));
    chk("full_hold_w_en", 69'(rf_w_en), 69'(1'b1));
    mem_valid = 1'b1; mem_addr = 5'd30; mem_data = 64'hBAD;
    @(posedge clk); #1;
    mem_valid = 1'b0;
    chk("full_count_kept", 69'(count), 69'(3'd4));
    chk("full_hold_addr", 69'(rf_addr), 69'(5'd16));
    chk("full_hold_data", 69'(rf_data), 69'(64'h1000));
    rf_stall = 1'b0;
    repeat (6) @(posedge clk); #1;
    chk("full_drain_count", 69'(count), 69'(3'd0));
    chk("full_drain_w_en", 69'(rf_w_en), 69'(1'b0));
    chk("full_drain_q", 69'(exp_q.size()), 69'(0));

    // bypass then flush with three pending entries
    rf_stall = 1'b1; fwd_addr_1 = 5'd7; fwd_addr_2 = 5'd6;
    #1;
    chk("byp_empty_hit", 69'(fwd_hit_1), 69'(1'b0));
    push_mem(5'd7, 64'h11);
    push_alu(5'd7, 64'h22, 1'b0, 12'd0, 64'h22);
    chk("byp_count", 69'(count), 69'(3'd1));
    chk("byp_out_data", 69'(rf_data), 69'(64'h11));
    chk("byp_miss_hit2", 69'(fwd_hit_2), 69'(1'b0));
`ifdef WRITEBACK_STAGE_BYPASS_EN
    chk("byp_hit1", 69'(fwd_hit_1), 69'(1'b1));
    chk("byp_data1", 69'(fwd_data_1), 69'(64'h22));
`else
    chk("byp_hit1", 69'(fwd_hit_1), 69'(1'b0));
    chk("byp_data1", 69'(fwd_data_1), 69'(64'h0));
`endif
    push_mem(5'd8, 64'h33);
    push_mem(5'd9, 64'h44);
    chk("flush_pre_count", 69'(count), 69'(3'd3));
    flush = 1'b1; mem_valid = 1'b1; mem_addr = 5'd12; mem_data = 64'h99;
    #1;
    chk("flush_mem_ready", 69'(mem_ready), 69'(1'b0));
    chk("flush_alu_ready", 69'(alu_ready), 69'(1'b0));
    @(posedge clk); #1;
    flush = 1'b0; mem_valid = 1'b0;
    exp_q.delete();
    chk("flush_count", 69'(count), 69'(3'd0));
    chk("flush_w_en", 69'(rf_w_en), 69'(1'b0));
    rf_stall = 1'b0;
    @(posedge clk); #1;
    chk("flush_count2", 69'(count), 69'(3'd0));
    chk("flush_hit", 69'(fwd_hit_1), 69'(1'b0));

    // asynchronous reset mid-stall
    rf_stall = 1'b1;
    push_mem(5'd10, 64'h55);
    push_mem(5'd11, 64'h66);
    chk("rst2_pre_w_en", 69'(rf_w_en), 69'(1'b1));
    #1 rst_n = 1'b0;
    #1;
    chk("rst2_w_en", 69'(rf_w_en), 69'(1'b0));
    chk("rst2_addr", 69'(rf_addr), 69'(5'd0));
    chk("rst2_data", 69'(rf_data), 69'(64'd0));
    chk("rst2_count", 69'(count), 69'(3'd0));
    chk("rst2_mem_ready", 69'(mem_ready), 69'(1'b0));
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1; rf_stall = 1'b0;
    push_alu(5'd12, 64'h77, 1'b0, 12'd0, 64'h77);
    repeat (3) @(posedge clk); #1;
    chk("final_count", 69'(count), 69'(3'd0));
    chk("final_q", 69'(exp_q.size()), 69'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of pending-write FIFO entries; legal values are 2, 4 and 8.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port flush  input  1  synchronous discard of all pending writes.
REQ-005 SHALL have ports alu_valid, alu_ready, alu_addr, alu_data, alu_imm_sel, alu_imm: input 1 / output 1 / input 5 / input 64 / input 1 / input 12; this is the ALU result channel.
REQ-006 SHALL have ports mem_valid, mem_ready, mem_addr, mem_data: input 1 / output 1 / input 5 / input 64; this is the load-result channel.
REQ-007 SHALL have port rf_stall  input  1  register file cannot take a write this cycle.
REQ-008 SHALL have ports rf_w_en, rf_addr, rf_data: output 1 / output 5 / output 64; this is the registered write port into the register-file stage.
REQ-009 SHALL have port count  output  $clog2(DEPTH)+1  number of FIFO entries.
REQ-010 SHALL have ports fwd_addr_1, fwd_addr_2  input  5  read addresses to check for bypass.
REQ-011 SHALL have ports fwd_hit_1, fwd_hit_2  output  1, and fwd_data_1, fwd_data_2  output  64; these form the bypass result.

Function
REQ-012 SHALL accept a channel on a posedge where its valid and ready are both high (handshake), pushing {addr, data} into the FIFO tail.
REQ-013 SHALL compute the ALU payload as {52'b0, alu_imm} when alu_imm_sel=1, else alu_data.
REQ-014 SHALL drive mem_ready = (count<DEPTH) && !flush.
REQ-015 SHALL drive alu_ready = (count<DEPTH) && !flush && !mem_valid, giving the memory channel fixed priority and accepting at most one push per cycle.
REQ-016 SHALL base the ready signals on the current count only, so a same-cycle pop does not free a slot for a push.
REQ-017 SHALL, at each posedge with the output register free (rf_w_en=0, or rf_stall=0) and count>0, load the head entry into rf_addr/rf_data, set rf_w_en=1 and pop the head.
REQ-018 SHALL clear rf_w_en at a posedge where the output register is free and the FIFO is empty.
REQ-019 SHALL hold rf_w_en/rf_addr/rf_data unchanged while rf_stall=1 and rf_w_en=1.
REQ-020 SHALL have a latency of 1 cycle, empty FIFO: accept at edge N gives rf_w_en=1 with that payload after edge N+1.
REQ-021 SHALL write entries in strict acceptance order, with no reordering or merging of same-address writes.
REQ-022 SHALL wrap the FIFO pointers modulo DEPTH; count updates +1 on push-only, -1 on pop-only, and stays unchanged on push and pop together.
REQ-023 SHALL, on flush=1 at a posedge, empty the FIFO (count=0), clear rf_w_en, and ignore that cycle's pushes; flush overrides rf_stall.

Reset
REQ-024 SHALL, on rst_n=0, immediately force count=0, FIFO pointers=0, rf_w_en=0, rf_addr=0, rf_data=0, independent of clk.
REQ-025 SHALL drop all pending writes when reset is asserted mid-operation.
REQ-026 SHALL hold alu_ready=mem_ready=0 while rst_n=0.
REQ-027 SHALL accept pushes starting at the first posedge after rst_n deasserts.

Configuration
REQ-028 SHALL provide the macro WRITEBACK_STAGE_BYPASS_EN.
REQ-029 SHALL, when WRITEBACK_STAGE_BYPASS_EN is defined, assert fwd_hit_k combinationally if fwd_addr_k matches any valid FIFO entry or the output register while rf_w_en=1.
REQ-030 SHALL, when WRITEBACK_STAGE_BYPASS_EN is defined, return as fwd_data_k the youngest match, in priority order FIFO tail to head, then the output register.
REQ-031 SHALL, when WRITEBACK_STAGE_BYPASS_EN is undefined, tie fwd_hit_1, fwd_hit_2, fwd_data_1 and fwd_data_2 to 0 and build no compare logic.

Verification
REQ-032 SHALL cover single write: ALU push addr=5, data=0xDEAD_BEEF -> next cycle rf_w_en=1, rf_addr=5, rf_data=0xDEADBEEF; the cycle after, rf_w_en=0.
REQ-033 SHALL cover arbitration: alu_valid and mem_valid together (ALU addr 1, mem addr 2) -> alu_ready=0; register file writes addr 2 then addr 1.
REQ-034 SHALL cover full/stall: rf_stall=1 with DEPTH=4 and 5 pushes -> count=4, ready=0, output held; release rf_stall -> 5 writes in order, count returns to 0.
REQ-035 SHALL cover immediate select: alu_imm_sel=1, alu_imm=0xABC, alu_data=all-ones -> rf_data=0x0000_0000_0000_0ABC.
REQ-036 SHALL cover flush and reset: flush with count=3 -> count=0 and rf_w_en=0 next edge; rst_n low mid-stall -> outputs 0 without a clock edge.
REQ-037 SHALL cover bypass with the macro defined: two pending writes to addr 7 (0x11 then 0x22), fwd_addr_1=7 -> fwd_hit_1=1, fwd_data_1=0x22; with the macro undefined -> fwd_hit_1=0.
